// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit framer and the receiver.
//   uart_state_t        : tx/rx state encoding (IDLE/START/DATA/PARITY/STOP)
//   DEFAULT_OVERSAMPLE  : clk cycles per bit (receiver samples mid-bit at 16x)
//   DEFAULT_DATA_BITS   : data bits per frame
//   even_parity()       : XOR of a data word, zero-extended to PARITY_FN_W bits
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

    // Wide enough for any legal DATA_BITS; zero padding does not change an XOR.
    localparam int PARITY_FN_W = 16;

    function automatic logic even_parity(input logic [PARITY_FN_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/uart_tx_framer.sv
// UART transmit framer. Accepts parallel words over a valid/ready handshake
// into a one-deep holding register and serialises them onto TxD as
// start bit, DATA_BITS data bits LSB first, optional even parity, stop bit(s).
// Each bit lasts OVERSAMPLE clk cycles. A word waiting in the holding
// register is reloaded on the final stop tick, so frames run back to back.
//
// Ports:
//   clk       in   single clock
//   reset     in   synchronous, active-high
//   tx_data   in   [DATA_BITS] word to send, sampled on accept
//   tx_valid  in   upstream has a word
//   tx_ready  out  holding register empty (and not in reset)
//   TxD       out  registered serial line, idles high
//   tx_busy   out  FSM not in IDLE
//   tx_done   out  one-cycle pulse at the end of each frame's last stop bit
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | line high, waiting for hold_valid
// ST_START   | TxD low for one bit period
// ST_DATA    | shifting out data bits LSB first, bit_cnt = current bit
// ST_PARITY  | TxD = parity latched when the word was loaded
// ST_STOP    | TxD high for STOP_BITS periods, bit_cnt = current stop bit
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int PARITY_EN  = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 TxD,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    uart_state_t          state;
    logic [TICK_W-1:0]    tick;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] hold_reg;
    logic                 hold_valid;
    logic                 parity_bit;
    logic                 tick_at_end;

    assign tick_at_end = (tick == TICK_LAST);

    // Depends only on registered state and reset, never on tx_valid.
    assign tx_ready = !hold_valid && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            TxD        <= 1'b1;
            hold_valid <= 1'b0;
            hold_reg   <= '0;
            tick       <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_done    <= 1'b0;
            tx_busy    <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            // Accept and reload never coincide: tx_ready is low while hold_valid is set.
            if (tx_valid && tx_ready) begin
                hold_reg   <= tx_data;
                hold_valid <= 1'b1;
            end

            if (state != ST_IDLE) begin
                tick <= tick_at_end ? '0 : tick + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    tick <= '0;
                    if (hold_valid) begin
                        shift_reg  <= hold_reg;
                        parity_bit <= even_parity(PARITY_FN_W'(hold_reg));
                        hold_valid <= 1'b0;
                        TxD        <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= ST_START;
                    end
                end

                ST_START: begin
                    if (tick_at_end) begin
                        TxD     <= shift_reg[0];
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (tick_at_end) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                TxD   <= parity_bit;
                                state <= ST_PARITY;
                            end else begin
                                TxD   <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            // Next bit is shift_reg[1] before the shift lands.
                            shift_reg <= shift_reg >> 1;
                            TxD       <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (tick_at_end) begin
                        TxD     <= 1'b1;
                        bit_cnt <= '0;
                        state   <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (tick_at_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            tx_done <= 1'b1;
                            bit_cnt <= '0;
                            if (hold_valid) begin
                                shift_reg  <= hold_reg;
                                parity_bit <= even_parity(PARITY_FN_W'(hold_reg));
                                hold_valid <= 1'b0;
                                TxD        <= 1'b0;
                                state      <= ST_START;
                            end else begin
                                TxD     <= 1'b1;
                                tx_busy <= 1'b0;
                                state   <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    TxD     <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: instance A uses defaults (8 data bits,
// even parity, 1 stop), instance B has no parity and 2 stop bits.
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, txd_a, busy_a, done_a;
    logic       ready_b, txd_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    logic exp_wave [0:399];
    logic exp_done [0:399];

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs [8];

    uart_tx_framer dut_a (
        .clk(clk), .reset(reset), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(ready_a), .TxD(txd_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    uart_tx_framer #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .reset(reset), .tx_data(data_b), .tx_valid(valid_b),
        .tx_ready(ready_b), .TxD(txd_b), .tx_busy(busy_b), .tx_done(done_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void clear_exp();
        for (int i = 0; i < 400; i++) begin
            exp_wave[i] = 1'b1;
            exp_done[i] = 1'b0;
        end
    endfunction

    // Writes one expected frame starting at cycle 'base'; returns the cycle
    // on which tx_done is expected (also the first cycle after the frame).
    function automatic int put_frame(input int base, input logic [7:0] d, input logic par,
                                     input bit pe, input int sb);
        int p;
        p = base;
        for (int k = 0; k < 16; k++) exp_wave[p++] = 1'b0;
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 16; k++) exp_wave[p++] = d[i];
        if (pe)
            for (int k = 0; k < 16; k++) exp_wave[p++] = par;
        for (int k = 0; k < 16 * sb; k++) exp_wave[p++] = 1'b1;
        exp_done[p] = 1'b1;
        return p;
    endfunction

    // Called between accept edge N and E0 = N+1; c = 0 is the cycle after E0.
    task automatic check_wave(input int len, input bit sel_b, input string name,
                              output logic [7:0] rx0, output logic [7:0] rx1, output logic rxp);
        int   bad;
        logic t, d, b, eb;
        bad = 0;
        rx0 = '0;
        rx1 = '0;
        rxp = 1'b0;
        @(posedge clk);
        for (int c = 0; c <= len; c++) begin
            @(negedge clk);
            t  = sel_b ? txd_b : txd_a;
            d  = sel_b ? done_b : done_a;
            b  = sel_b ? busy_b : busy_a;
            eb = (c < len);
            if (t !== exp_wave[c]) bad++;
            if (d !== exp_done[c]) bad++;
            if (b !== eb) bad++;
            for (int i = 0; i < 8; i++) begin
                if (c == 16 * (1 + i) + 8) rx0[i] = t;
                if (c == 176 + 16 * (1 + i) + 8) rx1[i] = t;
            end
            if (c == 16 * 9 + 8) rxp = t;
        end
        chk({name, "_wave"}, bad, 0);
    endtask

    task automatic accept(input bit sel_b, input logic [7:0] d, input string name);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!(sel_b ? ready_b : ready_a) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk({name, "_ready"}, sel_b ? ready_b : ready_a, 1);
        if (sel_b) begin
            data_b  = d;
            valid_b = 1'b1;
        end else begin
            data_a  = d;
            valid_a = 1'b1;
        end
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        @(negedge clk);
        chk({name, "_txd_before_start"}, sel_b ? txd_b : txd_a, 1);
        chk({name, "_busy_before_start"}, sel_b ? busy_b : busy_a, 0);
        chk({name, "_ready_held"}, sel_b ? ready_b : ready_a, 0);
    endtask

    task automatic idle_watch(input int n, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (txd_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b0 ||
                txd_b !== 1'b1 || done_b !== 1'b0) bad++;
        end
        chk({name, "_idle"}, bad, 0);
    endtask

    // Sends d with 0x12 buffered behind it, then resets at edge E0+cut.
    task automatic reset_abort(input logic [7:0] d, input int cut, input logic exp_txd,
                               input string name);
        @(negedge clk);
        data_a  = d;
        valid_a = 1'b1;
        @(posedge clk);
        #1 data_a = 8'h12;
        @(posedge clk);
        @(posedge clk);
        #1 valid_a = 1'b0;
        repeat (cut - 2) @(posedge clk);
        @(negedge clk);
        chk({name, "_txd_pre"}, txd_a, exp_txd);
        chk({name, "_busy_pre"}, busy_a, 1);
        chk({name, "_hold_full"}, ready_a, 0);
        reset = 1'b1;
        @(negedge clk);
        chk({name, "_txd_rst"}, txd_a, 1);
        chk({name, "_busy_rst"}, busy_a, 0);
        chk({name, "_done_rst"}, done_a, 0);
        chk({name, "_ready_in_rst"}, ready_a, 0);
        reset = 1'b0;
        @(negedge clk);
        chk({name, "_ready_after"}, ready_a, 1);
        idle_watch(250, name);
    endtask

    initial begin
        logic [7:0] r0, r1;
        logic       rp;
        int         n;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h01, 1'b1};
        vecs[2] = '{8'h3C, 1'b0};
        vecs[3] = '{8'hC3, 1'b0};
        vecs[4] = '{8'hFF, 1'b0};
        vecs[5] = '{8'h00, 1'b0};
        vecs[6] = '{8'h80, 1'b1};
        vecs[7] = '{8'h7F, 1'b1};

        reset   = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a  = 8'h00;
        data_b  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_txd", txd_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ready", ready_a, 0);
        chk("rst_txd_b", txd_b, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", ready_a, 1);

        for (int i = 0; i < 8; i++) begin
            clear_exp();
            n = put_frame(0, vecs[i].data, vecs[i].par, 1'b1, 1);
            accept(1'b0, vecs[i].data, $sformatf("vec%0d", i));
            check_wave(n, 1'b0, $sformatf("vec%0d", i), r0, r1, rp);
            chk($sformatf("vec%0d_data", i), r0, vecs[i].data);
            chk($sformatf("vec%0d_parity", i), rp, vecs[i].par);
        end

        // Back-to-back with tx_valid held; data changes while ready is low.
        clear_exp();
        n = put_frame(0, 8'h3C, 1'b0, 1'b1, 1);
        n = put_frame(n, 8'hC3, 1'b0, 1'b1, 1);
        @(negedge clk);
        data_a  = 8'h3C;
        valid_a = 1'b1;
        @(posedge clk);
        #1 data_a = 8'hC3;
        fork
            check_wave(n, 1'b0, "b2b", r0, r1, rp);
            begin
                @(negedge clk);
                chk("b2b_ready_full", ready_a, 0);
                @(posedge clk);
                @(negedge clk);
                chk("b2b_ready_after_load", ready_a, 1);
                @(posedge clk);
                #1;
                valid_a = 1'b0;
                data_a  = 8'h00;
                @(negedge clk);
                chk("b2b_backpressure", ready_a, 0);
                @(negedge clk);
                data_a = 8'hFF;
            end
        join
        chk("b2b_word0", r0, 8'h3C);
        chk("b2b_word1", r1, 8'hC3);

        // No parity, two stop bits.
        clear_exp();
        n = put_frame(0, 8'h55, 1'b0, 1'b0, 2);
        chk("var_frame_len", n, 176);
        accept(1'b1, 8'h55, "var");
        check_wave(n, 1'b1, "var", r0, r1, rp);
        chk("var_data", r0, 8'h55);

        reset_abort(8'hFF, 69, 1'b1, "rst_data");
        reset_abort(8'h00, 5, 1'b0, "rst_start");

        idle_watch(1000, "idle_line");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
